seq_alu: RTL



---
 rtl/alu_pkg.sv | 24 ++
 rtl/mul_shift_add.sv | 58 +++++
 rtl/seq_alu.sv | 102 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute stage: ALU control codes, FSM states and default widths.
// The ALU control decoder uses the same code constants.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_CNT_W = 5;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_XOR = 3'b001,
        ALU_SLL = 3'b010,
        ALU_ADD = 3'b011,
        ALU_SUB = 3'b100,
        ALU_MUL = 3'b101,
        ALU_SRA = 3'b110,
        ALU_RSV = 3'b111
    } alu_ctrl_e;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } alu_state_e;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative radix-2 shift-add multiplier returning the low WIDTH bits of the product.
// Optional macro SEQ_ALU_MUL_EARLY_EXIT_EN: finish as soon as the shifted multiplier is zero.
module mul_shift_add
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = ALU_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_start,
    input  logic             i_busy,
    input  logic [WIDTH-1:0] i_mcand,
    input  logic [WIDTH-1:0] i_mplier,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_last;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

`ifdef SEQ_ALU_MUL_EARLY_EXIT_EN
    // Once no multiplier bits remain after this step, the accumulator is already final.
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1)) || (r_mplier[WIDTH-1:1] == '0);
`else
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

    assign o_done    = i_busy && w_last;
    assign o_product = w_acc_next;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_mcand  <= i_mcand;
            r_mplier <= i_mplier;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Execute stage: single-cycle ALU ops plus an iterative MUL behind a valid/ready handshake.
// Optional macro SEQ_ALU_MUL_EARLY_EXIT_EN shortens MUL latency for small multipliers.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = ALU_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o
);

    alu_state_e       r_state;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_zero;

    logic             w_accept;
    logic             w_mul_start;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_res;
    logic [WIDTH-1:0] w_alu_res;
    logic [CNT_W-1:0] w_shamt;

    assign ready_o     = (r_state == IDLE);
    assign w_accept    = valid_i && ready_o;
    assign w_mul_start = w_accept && (ALUCtrl_i == ALU_MUL);
    assign w_shamt     = data2_i[CNT_W-1:0];

    // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
    always_comb begin
        w_alu_res = '0;
        case (ALUCtrl_i)
            ALU_AND: w_alu_res = data1_i & data2_i;
            ALU_XOR: w_alu_res = data1_i ^ data2_i;
            ALU_SLL: w_alu_res = data1_i << w_shamt;
            ALU_ADD: w_alu_res = data1_i + data2_i;
            ALU_SUB: w_alu_res = data1_i - data2_i;
            ALU_SRA: w_alu_res = $signed(data1_i) >>> w_shamt;
            default: w_alu_res = '0;
        endcase
    end

    mul_shift_add #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_start   (w_mul_start),
        .i_busy    (r_state == MUL_BUSY),
        .i_mcand   (data1_i),
        .i_mplier  (data2_i),
        .o_done    (w_mul_done),
        .o_product (w_mul_res)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_zero  <= 1'b1;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_mul_start) begin
                        r_state <= MUL_BUSY;
                    end else if (w_accept) begin
                        r_data  <= w_alu_res;
                        r_zero  <= (w_alu_res == '0);
                        r_valid <= 1'b1;
                    end
                end
                MUL_BUSY: begin
                    // Requests arriving while busy are ignored; upstream holds them.
                    if (w_mul_done) begin
                        r_data  <= w_mul_res;
                        r_zero  <= (w_mul_res == '0);
                        r_valid <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign zero_o  = r_zero;

endmodule
